// File: rtl/moving_average1_decimator_pkg.sv
// -----------------------------------------------------------------------------
// MovingAverage1_types
//   Shared types and width constants for the moving-average decimator slice.
//   sample_t : signed 8-bit window sum / mean sample
//   SUM_W    : width of the filter's window sum
//   MEAN_W   : width of the scaled mean
//   DROP_W   : width of the saturating drop counter
// -----------------------------------------------------------------------------
package MovingAverage1_types;

  localparam int SUM_W  = 8;
  localparam int MEAN_W = 8;
  localparam int DROP_W = 8;

  typedef logic signed [SUM_W-1:0] sample_t;

endpackage

// File: rtl/moving_average1_decimator_fifo.sv
// -----------------------------------------------------------------------------
// moving_average1_fifo
//   Small synchronous FIFO for decimated means. A push into a full FIFO is
//   accepted only when a pop happens on the same edge (occupancy unchanged).
//   The head is driven straight from storage and the read pointer, so it has
//   no combinational dependence on push/pop; it reads 0 while empty.
// Ports:
//   system1000      in  clock, rising edge
//   system1000_rstn in  asynchronous reset, active low
//   push / din      in  write request and data
//   pop             in  read request (ignored while empty)
//   head            out oldest entry, 0 when empty
//   full / empty    out occupancy flags
// -----------------------------------------------------------------------------
module moving_average1_fifo
  import MovingAverage1_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    system1000,
  input  logic    system1000_rstn,
  input  logic    push,
  input  sample_t din,
  input  logic    pop,
  output sample_t head,
  output logic    full,
  output logic    empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  // One extra bit so a full FIFO (count == DEPTH) differs from an empty one.
  logic [PTR_W:0]   count_reg;
  sample_t          mem [DEPTH];

  logic do_pop;
  logic do_push;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // Full FIFO still takes the new value if the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; stale entries are masked by the empty flag.
  always_ff @(posedge system1000) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  assign head = empty ? sample_t'(0) : mem[rd_ptr_reg];

endmodule

// File: rtl/moving_average1_decimator.sv
// -----------------------------------------------------------------------------
// moving_average1_decimator
//   Takes the per-cycle signed window sum of a 4-tap moving-average filter,
//   divides it by 4 (arithmetic shift) and keeps one mean every DECIM enabled
//   samples. Results queue in a FIFO and leave on a valid/ready stream. A
//   result that finds the FIFO full with no pop is dropped and counted.
//   Build option: define MOVAVG_ROUND_EN to round half up ((sum+2)>>>2)
//   instead of flooring (sum>>>2).
// Ports:
//   system1000      in  clock, rising edge
//   system1000_rstn in  asynchronous reset, active low
//   sum_i           in  signed 8-bit window sum
//   sample_en_i     in  qualifies sum_i, advances the decimation phase
//   clear_i         in  synchronous clear of overflow_o / drop_count_o
//   out_data_o      out FIFO head mean (0 when empty)
//   out_valid_o     out FIFO non-empty
//   out_ready_i     in  consumer takes the head when high with out_valid_o
//   overflow_o      out sticky: a result was dropped
//   drop_count_o    out dropped-result count, saturating at 255
// -----------------------------------------------------------------------------
module moving_average1_decimator
  import MovingAverage1_types::*;
#(
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     system1000,
  input  logic                     system1000_rstn,
  input  logic signed [SUM_W-1:0]  sum_i,
  input  logic                     sample_en_i,
  input  logic                     clear_i,
  output logic signed [MEAN_W-1:0] out_data_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     overflow_o,
  output logic [DROP_W-1:0]        drop_count_o
);

  // DECIM = 1 still gets a one-bit counter that simply stays at 0.
  localparam int                 PHASE_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DECIM - 1);

  logic [PHASE_W-1:0] phase_reg;
  logic [PHASE_W-1:0] phase_next;
  logic               tick;

  logic signed [SUM_W:0] sum_wide;
  logic signed [SUM_W:0] sum_biased;
  sample_t               mean;

  logic               overflow_reg;
  logic [DROP_W-1:0]  drop_count_reg;

  sample_t fifo_head;
  logic    fifo_full;
  logic    fifo_empty;
  logic    pop;
  logic    drop;

  // ---------------- decimation phase ----------------
  assign tick = sample_en_i && (phase_reg == PHASE_LAST);

  always_comb begin
    phase_next = phase_reg;
    if (tick)             phase_next = '0;
    else if (sample_en_i) phase_next = phase_reg + 1'b1;
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) phase_reg <= '0;
    else                  phase_reg <= phase_next;
  end

  // ---------------- scaling to mean ----------------
  // Nine bits keep the +2 bias from wrapping at sum = 127; the shifted
  // value always lies in -32..32 so dropping the top bit is lossless.
  assign sum_wide = {sum_i[SUM_W-1], sum_i};
`ifdef MOVAVG_ROUND_EN
  assign sum_biased = sum_wide + 9'sd2;
`else
  assign sum_biased = sum_wide;
`endif
  assign mean = sample_t'(sum_biased >>> 2);

  // ---------------- output FIFO ----------------
  assign pop  = out_valid_o && out_ready_i;
  assign drop = tick && fifo_full && !pop;

  moving_average1_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .system1000      (system1000),
    .system1000_rstn (system1000_rstn),
    .push            (tick),
    .din             (mean),
    .pop             (pop),
    .head            (fifo_head),
    .full            (fifo_full),
    .empty           (fifo_empty)
  );

  assign out_data_o  = fifo_head;
  assign out_valid_o = !fifo_empty;

  // ---------------- drop accounting ----------------
  // Clear has priority over a coincident drop.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else if (clear_i) begin
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
      if (drop_count_reg != '1) drop_count_reg <= drop_count_reg + 1'b1;
    end
  end

  assign overflow_o   = overflow_reg;
  assign drop_count_o = drop_count_reg;

endmodule

// File: tb/tb_moving_average1_decimator.sv
// -----------------------------------------------------------------------------
// tb_moving_average1_decimator
//   Three instances (DECIM = 4, 1, 2) share all inputs; `sel` picks which one
//   a directed step observes. Expected means are queued when a tick is driven
//   and compared whenever the observed instance hands over a result.
// -----------------------------------------------------------------------------
module tb_moving_average1_decimator;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic signed [7:0] sum = '0;
  logic              en = 1'b0;
  logic              clear = 1'b0;
  logic              ready = 1'b0;

  logic signed [7:0] data4, data1, data2;
  logic              valid4, valid1, valid2;
  logic              ovf4, ovf1, ovf2;
  logic [7:0]        drop4, drop1, drop2;

  int sel = 4;
  int n_cmp = 0;
  int n_err = 0;
  logic signed [7:0] exp_q[$];

  always #5 clk = ~clk;

  moving_average1_decimator #(.DECIM(4), .FIFO_DEPTH(4)) dut4 (
    .system1000(clk), .system1000_rstn(rst_n), .sum_i(sum), .sample_en_i(en),
    .clear_i(clear), .out_data_o(data4), .out_valid_o(valid4),
    .out_ready_i(ready), .overflow_o(ovf4), .drop_count_o(drop4));

  moving_average1_decimator #(.DECIM(1), .FIFO_DEPTH(4)) dut1 (
    .system1000(clk), .system1000_rstn(rst_n), .sum_i(sum), .sample_en_i(en),
    .clear_i(clear), .out_data_o(data1), .out_valid_o(valid1),
    .out_ready_i(ready), .overflow_o(ovf1), .drop_count_o(drop1));

  moving_average1_decimator #(.DECIM(2), .FIFO_DEPTH(4)) dut2 (
    .system1000(clk), .system1000_rstn(rst_n), .sum_i(sum), .sample_en_i(en),
    .clear_i(clear), .out_data_o(data2), .out_valid_o(valid2),
    .out_ready_i(ready), .overflow_o(ovf2), .drop_count_o(drop2));

  function automatic logic get_valid();
    case (sel)
      1:       return valid1;
      2:       return valid2;
      default: return valid4;
    endcase
  endfunction

  function automatic logic signed [7:0] get_data();
    case (sel)
      1:       return data1;
      2:       return data2;
      default: return data4;
    endcase
  endfunction

  function automatic logic get_ovf();
    case (sel)
      1:       return ovf1;
      2:       return ovf2;
      default: return ovf4;
    endcase
  endfunction

  function automatic logic [7:0] get_drop();
    case (sel)
      1:       return drop1;
      2:       return drop2;
      default: return drop4;
    endcase
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compare a result the DUT is handing over on the coming edge.
  task automatic check_pop();
    logic signed [7:0] ev;
    if (get_valid() && ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        ev = exp_q.pop_front();
        check("pop_data", get_data(), ev);
        $display("pop   dut%0d data=%0d exp=%0d", sel, get_data(), ev);
      end
    end
  endtask

  // One clock: compare any pop, queue an expected push, advance to edge+1.
  task automatic cycle(input bit push, input logic signed [7:0] ev);
    check_pop();
    if (push) exp_q.push_back(ev);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic signed [7:0] scale_sum [4] = '{8'sd6, -8'sd6, 8'sd127, -8'sd128};
`ifdef MOVAVG_ROUND_EN
  logic signed [7:0] scale_exp [4] = '{8'sd2, -8'sd1, 8'sd32, -8'sd32};
`else
  logic signed [7:0] scale_exp [4] = '{8'sd1, -8'sd2, 8'sd31, -8'sd32};
`endif
  logic signed [7:0] ramp_sum  [6] = '{8'sd4, 8'sd8, 8'sd12, 8'sd16, 8'sd20, 8'sd24};

  initial begin
    // ---------- reset state ----------
    do_reset();
    sel = 1;
    check("rst_valid", get_valid(), 0);
    check("rst_data", get_data(), 0);
    check("rst_drop", get_drop(), 0);
    check("rst_ovf", get_ovf(), 0);

    // ---------- async reset mid-stream with 3 entries held ----------
    ready = 1'b0; en = 1'b1; sum = 8'sd20;
    repeat (3) cycle(0, 0);
    check("prerst_valid", get_valid(), 1);
    check("prerst_data", get_data(), 5);
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", get_valid(), 0);
    check("midrst_data", get_data(), 0);
    check("midrst_drop", get_drop(), 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    $display("reset asserted mid-stream, FIFO discarded");

    // ---------- first result after 4 enabled samples (DECIM=4) ----------
    sel = 4; ready = 1'b1; en = 1'b1; sum = 8'sd20;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0);
      check("first_wait_valid", get_valid(), 0);
    end
    cycle(1, 5);
    check("first_valid", get_valid(), 1);
    check("first_data", get_data(), 5);

    // ---------- steady flow ----------
    for (int i = 0; i < 16; i++) begin
      cycle((i % 4) == 3, 5);
      check("steady_valid", get_valid(), ((i % 4) == 3) ? 1 : 0);
    end
    cycle(0, 0);
    check("steady_drop", get_drop(), 0);
    check("steady_ovf", get_ovf(), 0);

    // ---------- scaling (DECIM=1) ----------
    do_reset();
    sel = 1; ready = 1'b1; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sum = scale_sum[i];
      cycle(1, scale_exp[i]);
    end
    en = 1'b0;
    repeat (2) cycle(0, 0);
    check("scale_sb_empty", exp_q.size(), 0);

    // ---------- back-pressure / overflow ----------
    do_reset();
    sel = 1; ready = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sum = ramp_sum[i];
      cycle(i < 4, 8'(i + 1));
    end
    en = 1'b0;
    check("bp_ovf", get_ovf(), 1);
    check("bp_drop", get_drop(), 2);
    check("bp_head", get_data(), 1);
    ready = 1'b1;
    repeat (4) cycle(0, 0);
    check("bp_drained_valid", get_valid(), 0);
    check("bp_sb_empty", exp_q.size(), 0);

    // ---------- full FIFO + simultaneous pop ----------
    do_reset();
    sel = 1; ready = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sum = ramp_sum[i];
      cycle(1, 8'(i + 1));
    end
    sum = 8'sd40; ready = 1'b1;
    cycle(1, 10);
    en = 1'b0;
    check("fullpop_drop", get_drop(), 0);
    check("fullpop_ovf", get_ovf(), 0);
    repeat (3) cycle(0, 0);
    check("fullpop_last_valid", get_valid(), 1);
    check("fullpop_tail", get_data(), 10);
    cycle(0, 0);
    check("fullpop_empty", get_valid(), 0);
    check("fullpop_sb_empty", exp_q.size(), 0);

    // ---------- drop saturation and clear ----------
    do_reset();
    sel = 1; ready = 1'b0; en = 1'b1; sum = 8'sd0;
    repeat (4 + 254) cycle(0, 0);
    check("sat_254", get_drop(), 254);
    cycle(0, 0);
    check("sat_255", get_drop(), 255);
    repeat (45) cycle(0, 0);
    check("sat_hold", get_drop(), 255);
    check("sat_ovf", get_ovf(), 1);
    clear = 1'b1;
    cycle(0, 0);
    clear = 1'b0;
    check("clear_drop", get_drop(), 0);
    check("clear_ovf", get_ovf(), 0);
    cycle(0, 0);
    check("post_clear_drop", get_drop(), 1);

    // ---------- enable gating (DECIM=2) ----------
    do_reset();
    sel = 2; ready = 1'b1; sum = -8'sd20;
    for (int i = 0; i < 16; i++) begin
      en = ((i % 2) == 0);
      cycle((i % 4) == 2, -5);
      check("gate_valid", get_valid(), ((i % 4) == 2) ? 1 : 0);
    end
    en = 1'b0;
    repeat (2) cycle(0, 0);
    check("gate_sb_empty", exp_q.size(), 0);
    check("gate_drop", get_drop(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
